// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//   Modulo-MODULO up/down counter with enable, synchronous parallel load,
//   clock prescaler, terminal-count and wrap flags. With default parameters it
//   behaves as a 3-bit 0..7 free-running up-counter.
//
// Parameters
//   WIDTH    : bit width of count and load_val
//   MODULO   : count range 0..MODULO-1 (2 <= MODULO <= 2**WIDTH)
//   PRESCALE : enabled clock cycles per count step (>= 1)
//
// Ports
//   clk      : system clock, all state updates on rising edge
//   rst      : synchronous active-high reset
//   en       : count enable, gates both the prescaler and the count step
//   up_dn    : 1 = count up, 0 = count down
//   load     : synchronous parallel load strobe (overrides en)
//   load_val : value to load, clamped to MODULO-1 when out of range
//   count    : current count (registered)
//   tc       : terminal count (combinational from count and up_dn)
//   wrap     : registered one-cycle pulse coincident with a wrapped count
//
// Optional build macro
//   COUNTER_SAT_EN : when defined, the counter saturates at the terminal value
//                    instead of wrapping, and wrap is held at 0.
// -----------------------------------------------------------------------------
module mod_updown_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULO   = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Prescaler needs at least one bit even when PRESCALE == 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // MODULO-1 is formed before narrowing so MODULO == 2**WIDTH still gives
    // an all-ones terminal value rather than overflowing the constant.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    localparam logic [PW-1:0]    P_MAX   = PW'(PRESCALE - 1);

    generate
        if ((MODULO < 2) || (MODULO > (1 << WIDTH))) begin : g_bad_modulo
            $error("mod_updown_counter: MODULO out of range 2..2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("mod_updown_counter: PRESCALE must be >= 1");
        end
    endgenerate

    logic [PW-1:0]    p;
    logic [PW-1:0]    p_next;
    logic [WIDTH-1:0] count_next;
    logic             wrap_next;

    always_comb begin
        count_next = count;
        p_next     = p;
        wrap_next  = 1'b0;

        if (load) begin
            count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            p_next     = '0;
        end else if (en) begin
            if (p == P_MAX) begin
                p_next = '0;
                // Count step for this enabled cycle.
                if (up_dn) begin
                    if (count == MAX_VAL) begin
`ifdef COUNTER_SAT_EN
                        count_next = count;
`else
                        count_next = '0;
                        wrap_next  = 1'b1;
`endif
                    end else begin
                        count_next = count + WIDTH'(1);
                    end
                end else begin
                    if (count == '0) begin
`ifdef COUNTER_SAT_EN
                        count_next = count;
`else
                        count_next = MAX_VAL;
                        wrap_next  = 1'b1;
`endif
                    end else begin
                        count_next = count - WIDTH'(1);
                    end
                end
            end else begin
                p_next = p + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            p     <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            p     <= p_next;
            wrap  <= wrap_next;
        end
    end

    assign tc = (up_dn && (count == MAX_VAL)) || (!up_dn && (count == '0));

endmodule
